// File: rtl/aes_key_expansion.sv
// AES-128 key schedule: expands a cipher key into round keys 0..NUM_ROUNDS,
// one per cycle, through an external combinational S-box, and serves them by index.
module aes_key_expansion #(
  parameter int NUM_ROUNDS = 10
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         init,
  input  logic [127:0] key,
  input  logic [3:0]   round,
  output logic [127:0] round_key,
  output logic [31:0]  sboxw,
  input  logic [31:0]  new_sboxw,
  output logic         ready,
  output logic [0:0]   o_dbg_state
);

  localparam logic [0:0] S_IDLE = 1'b0;
  localparam logic [0:0] S_GEN  = 1'b1;
  localparam logic [3:0] LAST   = 4'(NUM_ROUNDS);

  // Handshake: init is a request that is accepted only on an edge where ready=1;
  // while ready=0 init and key are ignored, and ready=1 means every round key is valid.
  logic [127:0] r_key_mem [0:NUM_ROUNDS];
  logic [0:0]   r_state;
  logic [3:0]   r_round_ctr;
  logic [7:0]   r_rcon;
  logic         r_ready;

  logic [3:0]   w_prev_idx;
  logic [127:0] w_prev;
  logic [31:0]  w_t;
  logic [31:0]  w_n0, w_n1, w_n2, w_n3;

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (8'h1b & {8{b[7]}});
  endfunction

  // The index is held at 0 outside GEN so the read never leaves the memory range.
  always_comb begin
    w_prev_idx = (r_state == S_GEN) ? (r_round_ctr - 4'd1) : 4'd0;
    w_prev     = r_key_mem[w_prev_idx];
    sboxw      = (r_state == S_GEN) ? w_prev[31:0] : 32'h0;
    w_t        = {new_sboxw[23:0], new_sboxw[31:24]} ^ {r_rcon, 24'h0};
    w_n0       = w_prev[127:96] ^ w_t;
    w_n1       = w_prev[95:64]  ^ w_n0;
    w_n2       = w_prev[63:32]  ^ w_n1;
    w_n3       = w_prev[31:0]   ^ w_n2;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= S_IDLE;
      r_ready     <= 1'b1;
      r_round_ctr <= 4'd0;
      r_rcon      <= 8'h01;
      for (int i = 0; i <= NUM_ROUNDS; i++) r_key_mem[i] <= 128'h0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (init) begin
            r_key_mem[0] <= key;
            r_round_ctr  <= 4'd1;
            r_rcon       <= 8'h01;
            r_ready      <= 1'b0;
            r_state      <= S_GEN;
          end
        end
        default: begin
          r_key_mem[r_round_ctr] <= {w_n0, w_n1, w_n2, w_n3};
          r_rcon                 <= xtime(r_rcon);
          if (r_round_ctr == LAST) begin
            r_ready     <= 1'b1;
            r_round_ctr <= 4'd0;
            r_state     <= S_IDLE;
          end else begin
            r_round_ctr <= r_round_ctr + 4'd1;
          end
        end
      endcase
    end
  end

  assign round_key   = (round <= LAST) ? r_key_mem[round] : 128'h0;
  assign ready       = r_ready;
  assign o_dbg_state = r_state;

endmodule

// File: tb/tb_aes_key_expansion.sv
// Bench for aes_key_expansion: supplies the S-box, drives init sequences and
// checks every round key against a word-level FIPS-197 key schedule model.
module tb_aes_key_expansion;

  logic         clk = 1'b0;
  logic         reset;
  logic         init;
  logic [127:0] key;
  logic [3:0]   round;
  logic [127:0] round_key;
  logic [31:0]  sboxw;
  logic [31:0]  new_sboxw;
  logic         ready;
  logic [0:0]   dbg_state;

  int total = 0;
  int bad   = 0;

  logic [7:0]   sbox_tab [256];
  logic [127:0] mdl_keys [0:10];
  logic [127:0] exp_q [$];

  typedef struct {
    logic [127:0] key;
    logic [127:0] rk1;
    logic [127:0] rk10;
  } vec_t;
  vec_t vecs [2];

  aes_key_expansion #(.NUM_ROUNDS(10)) dut (
    .clk(clk), .reset(reset), .init(init), .key(key), .round(round),
    .round_key(round_key), .sboxw(sboxw), .new_sboxw(new_sboxw),
    .ready(ready), .o_dbg_state(dbg_state)
  );

  // clock
  always #5 clk = ~clk;

  assign new_sboxw = {sbox_tab[sboxw[31:24]], sbox_tab[sboxw[23:16]],
                      sbox_tab[sboxw[15:8]],  sbox_tab[sboxw[7:0]]};

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p = 8'h0;
    for (int i = 0; i < 8; i++) begin
      if (b[0]) p = p ^ a;
      a = a[7] ? ((a << 1) ^ 8'h1b) : (a << 1);
      b = b >> 1;
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] b, input int n);
    return (b << n) | (b >> (8 - n));
  endfunction

  task automatic build_sbox();
    logic [7:0] inv;
    for (int x = 0; x < 256; x++) begin
      inv = 8'h0;
      for (int y = 1; y < 256; y++)
        if (x != 0 && gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
      sbox_tab[x] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3)
                    ^ rotl8(inv, 4) ^ 8'h63;
    end
  endtask

  function automatic logic [31:0] sub_word(input logic [31:0] w);
    return {sbox_tab[w[31:24]], sbox_tab[w[23:16]], sbox_tab[w[15:8]], sbox_tab[w[7:0]]};
  endfunction

  // FIPS-197 word recurrence over w[0..43]
  task automatic model(input logic [127:0] k);
    logic [31:0] w [44];
    logic [31:0] temp;
    logic [7:0]  rc;
    rc = 8'h01;
    for (int i = 0; i < 4; i++) w[i] = k[127 - 32*i -: 32];
    for (int i = 4; i < 44; i++) begin
      temp = w[i-1];
      if (i % 4 == 0) begin
        temp = sub_word({temp[23:0], temp[31:24]}) ^ {rc, 24'h0};
        rc = gmul(rc, 8'h02);
      end
      w[i] = w[i-4] ^ temp;
    end
    for (int r = 0; r <= 10; r++) mdl_keys[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
  endtask

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%h want=%h", name, act, exp);
    end
  endtask

  function automatic logic [127:0] rand_key();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  // driver: pulse init, optionally re-pulse init at a given low cycle, count ready-low cycles
  task automatic run_init(input logic [127:0] k, input int reinit_at, output int low_cycles);
    init = 1'b1;
    key  = k;
    @(negedge clk);
    init = 1'b0;
    key  = rand_key();
    round = 4'd0;
    #1;
    check("rk0_during_gen", round_key, k);
    check("sboxw_first_gen", {96'h0, sboxw}, {96'h0, k[31:0]});
    check("state_gen", {127'h0, dbg_state}, 128'h1);
    low_cycles = 0;
    while (ready == 1'b0 && low_cycles < 50) begin
      low_cycles++;
      init = (low_cycles == reinit_at);
      if (init) key = rand_key();
      @(negedge clk);
    end
    init = 1'b0;
    if (ready == 1'b0) check("ready_timeout", 128'h0, 128'h1);
  endtask

  // scoreboard: push model keys, pop while sweeping round
  task automatic check_all(input logic [127:0] k);
    model(k);
    for (int r = 0; r <= 10; r++) exp_q.push_back(mdl_keys[r]);
    for (int r = 0; r <= 10; r++) begin
      round = 4'(r);
      #1;
      check($sformatf("rk%0d", r), round_key, exp_q.pop_front());
    end
  endtask

  initial begin
    int low;
    logic [127:0] kb;
    vecs[0] = '{128'h2b7e151628aed2a6abf7158809cf4f3c,
                128'ha0fafe1788542cb123a339392a6c7605,
                128'hd014f9a8c9ee2589e13f0cc8b6630ca6};
    vecs[1] = '{128'h0,
                128'h62636363626363636263636362636363,
                128'hb4ef5bcb3e92e21123e951cf6f8f188e};
    build_sbox();

    reset = 1'b1; init = 1'b0; key = 128'h0; round = 4'd0;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    #1;
    check("reset_ready", {127'h0, ready}, 128'h1);
    check("reset_sboxw", {96'h0, sboxw}, 128'h0);
    check("reset_rk0", round_key, 128'h0);
    check("reset_state", {127'h0, dbg_state}, 128'h0);

    // known-answer vectors
    for (int v = 0; v < 2; v++) begin
      run_init(vecs[v].key, -1, low);
      check("ready_low_cycles", 128'(low), 128'd10);
      round = 4'd1;  #1; check("kat_rk1", round_key, vecs[v].rk1);
      round = 4'd10; #1; check("kat_rk10", round_key, vecs[v].rk10);
      round = 4'd0;  #1; check("kat_rk0", round_key, vecs[v].key);
      check_all(vecs[v].key);
    end

    // init re-asserted at cycle 3 with a different key is ignored
    @(negedge clk);
    run_init(vecs[0].key, 2, low);
    check("reinit_low_cycles", 128'(low), 128'd10);
    check_all(vecs[0].key);

    // reset mid-expansion aborts
    init = 1'b1; key = vecs[1].key;
    @(negedge clk);
    init = 1'b0;
    repeat (4) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    #1;
    check("abort_ready", {127'h0, ready}, 128'h1);
    check("abort_sboxw", {96'h0, sboxw}, 128'h0);
    for (int r = 0; r < 16; r++) begin
      round = 4'(r);
      #1;
      check($sformatf("abort_rk%0d", r), round_key, 128'h0);
    end
    @(negedge clk);
    run_init(vecs[0].key, -1, low);
    check("after_abort_low", 128'(low), 128'd10);
    check_all(vecs[0].key);

    // out-of-range round indices
    for (int r = 11; r < 16; r++) begin
      round = 4'(r);
      #1;
      check($sformatf("oor_rk%0d", r), round_key, 128'h0);
    end

    // back-to-back random keys: next init on the same negedge ready is seen high
    @(negedge clk);
    for (int n = 0; n < 4; n++) begin
      kb = rand_key();
      run_init(kb, -1, low);
      check("b2b_low_cycles", 128'(low), 128'd10);
      check_all(kb);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
